dual_width_rr_arbiter: RTL and testbench

Two-requester arbiter that shares one registered output channel between a SIZE-bit stream (in1) and a fixed 6-bit stream (in2). It sits in front of the dual passthrough datapath and sequences which source drives the shared output on each transfer. It uses round-robin with a bounded burst length, a valid/ready handshake on every channel, and a one-entry output register. SIZE is a `parameter` and must be overridable by `defparam`. SIZETWO is a `localparam`.

---
 rtl/dual_width_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_dual_width_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dual_width_rr_arbiter.sv
// dual_width_rr_arbiter
// Shares one registered output channel between a SIZE-bit requester (in1) and
// a fixed 6-bit requester (in2) using round-robin with a bounded burst length.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in1_data/valid/ready    requester 1 (SIZE bits), ready is combinational
//   in2_data/valid/ready    requester 2 (6 bits), ready is combinational
//   out_data/src/valid      registered output word, source tag, valid
//   out_ready               consumer accepts out_data
module dual_width_rr_arbiter #(
    parameter int SIZE  = 8,
    parameter int BURST = 4,
    localparam int unsigned SIZETWO = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SIZE-1:0]    in1_data,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [SIZETWO-1:0] in2_data,
    input  logic               in2_valid,
    output logic               in2_ready,
    output logic [SIZE-1:0]    out_data,
    output logic               out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G1   = 2'd1,
        ST_G2   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_src;
    logic [SIZE-1:0]  r_out_data;
    logic             r_out_src;
    logic             r_out_valid;

    logic             w_load;
    logic             w_cnt_below;
    logic             w_grant1;
    logic             w_grant2;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Output register can take a new word when empty or being drained.
    assign w_load      = !r_out_valid || out_ready;
    assign w_cnt_below = (r_cnt < BURST_C);

    // Arbitration decision; only evaluated when the output register can load.
    always_comb begin
        w_grant1    = 1'b0;
        w_grant2    = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_load) begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie the requester that was not served last wins.
                    if (in1_valid && (!in2_valid || r_last_src)) begin
                        w_grant1    = 1'b1;
                        w_state_nxt = ST_G1;
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (in2_valid) begin
                        w_grant2    = 1'b1;
                        w_state_nxt = ST_G2;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_G1: begin
                    if (in1_valid && (w_cnt_below || !in2_valid)) begin
                        w_grant1  = 1'b1;
                        w_cnt_nxt = w_cnt_below ? r_cnt + CNT_W'(1) : BURST_C;
                    end else if (in2_valid) begin
                        w_grant2    = 1'b1;
                        w_state_nxt = ST_G2;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_G2: begin
                    if (in2_valid && (w_cnt_below || !in1_valid)) begin
                        w_grant2  = 1'b1;
                        w_cnt_nxt = w_cnt_below ? r_cnt + CNT_W'(1) : BURST_C;
                    end else if (in1_valid) begin
                        w_grant1    = 1'b1;
                        w_state_nxt = ST_G1;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Readies are forced low while reset is asserted.
    assign in1_ready = w_grant1 && reset_n;
    assign in2_ready = w_grant2 && reset_n;

    // State, burst counter, round-robin memory and the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_last_src  <= 1'b1;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant1) begin
                r_out_data  <= in1_data;
                r_out_src   <= 1'b0;
                r_out_valid <= 1'b1;
                r_last_src  <= 1'b0;
            end else if (w_grant2) begin
                r_out_data  <= SIZE'(in2_data);
                r_out_src   <= 1'b1;
                r_out_valid <= 1'b1;
                r_last_src  <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_dual_width_rr_arbiter.sv
module tb_dual_width_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [5:0] in2_data;
    logic       in2_valid;
    logic       in2_ready;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_valid;
    logic       out_ready;

    // Second instance with SIZE = 12, fed only by requester 2.
    logic [11:0] w12_in1_data  = 12'hABC;
    logic        w12_in1_valid = 1'b0;
    logic        w12_in1_ready;
    logic [5:0]  w12_in2_data  = 6'h2A;
    logic        w12_in2_valid = 1'b1;
    logic        w12_in2_ready;
    logic [11:0] w12_out_data;
    logic        w12_out_src;
    logic        w12_out_valid;
    logic        w12_out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dual_width_rr_arbiter #(.SIZE(8), .BURST(4)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in2_data  (in2_data),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    dual_width_rr_arbiter #(.SIZE(12)) u_dut12 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in1_data  (w12_in1_data),
        .in1_valid (w12_in1_valid),
        .in1_ready (w12_in1_ready),
        .in2_data  (w12_in2_data),
        .in2_valid (w12_in2_valid),
        .in2_ready (w12_in2_ready),
        .out_data  (w12_out_data),
        .out_src   (w12_out_src),
        .out_valid (w12_out_valid),
        .out_ready (w12_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic [7:0] d1,
                         input logic v2, input logic [5:0] d2, input logic ordy);
        in1_valid = v1;
        in1_data  = d1;
        in2_valid = v2;
        in2_data  = d2;
        out_ready = ordy;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic e1, input logic e2);
        chk({tag, ".in1_ready"}, 32'(in1_ready), 32'(e1));
        chk({tag, ".in2_ready"}, 32'(in2_ready), 32'(e2));
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic es, input logic [7:0] ed);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_src"},   32'(out_src),   32'(es));
        chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    endtask

    initial begin
        logic       exp_src;
        logic [7:0] exp_d;

        // Reset held with both requesters valid: readies and outputs must be 0.
        reset_n = 1'b0;
        drive(1'b1, 8'hAA, 1'b1, 6'h11, 1'b1);
        #1;
        chk_rdy("rst", 1'b0, 1'b0);
        chk_out("rst", 1'b0, 1'b0, 8'h00);
        edge_wait();
        edge_wait();
        chk_out("rst_hold", 1'b0, 1'b0, 8'h00);

        // Release with both valid; in1 wins the first tie, then bursts of 4.
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_src = ((i / 4) % 2) == 1;
            drive(1'b1, 8'h10 + 8'(i), 1'b1, 6'(i + 1), 1'b1);
            chk_rdy($sformatf("burst%0d", i), !exp_src, exp_src);
            exp_d = exp_src ? {2'b00, 6'(i + 1)} : 8'h10 + 8'(i);
            edge_wait();
            chk_out($sformatf("burst%0d", i), 1'b1, exp_src, exp_d);
        end

        // Asynchronous reset mid-stream discards the word in flight.
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 8'h00);
        chk_rdy("async_rst", 1'b0, 1'b0);
        edge_wait();
        reset_n = 1'b1;
        drive(1'b1, 8'h5C, 1'b1, 6'h07, 1'b1);
        chk_rdy("rst_first", 1'b1, 1'b0);
        edge_wait();
        chk_out("rst_first", 1'b1, 1'b0, 8'h5C);

        // Lone in2 requester is served every cycle past the burst limit.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'hEE, 1'b1, 6'h3F, 1'b1);
            chk_rdy($sformatf("lone%0d", i), 1'b0, 1'b1);
            edge_wait();
            chk_out($sformatf("lone%0d", i), 1'b1, 1'b1, 8'h3F);
        end

        // Backpressure: output holds, no readies, state and count frozen.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h77, 1'b1, 6'h15, 1'b0);
            chk_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
            edge_wait();
            chk_out($sformatf("bp%0d", i), 1'b1, 1'b1, 8'h3F);
        end
        // in2 tenure already at burst limit, so in1 takes over on release.
        drive(1'b1, 8'h77, 1'b1, 6'h15, 1'b1);
        chk_rdy("bp_rel", 1'b1, 1'b0);
        edge_wait();
        chk_out("bp_rel", 1'b1, 1'b0, 8'h77);

        // Nobody valid: back to IDLE, output goes invalid.
        drive(1'b0, 8'h00, 1'b0, 6'h00, 1'b1);
        chk_rdy("idle", 1'b0, 1'b0);
        edge_wait();
        chk(("idle.out_valid"), 32'(out_valid), 32'd0);

        // in1 sends two words alone, then drops; in2 takes over with cnt = 1.
        drive(1'b1, 8'hA1, 1'b0, 6'h00, 1'b1);
        chk_rdy("ho0", 1'b1, 1'b0);
        edge_wait();
        chk_out("ho0", 1'b1, 1'b0, 8'hA1);
        drive(1'b1, 8'hA2, 1'b0, 6'h00, 1'b1);
        chk_rdy("ho1", 1'b1, 1'b0);
        edge_wait();
        chk_out("ho1", 1'b1, 1'b0, 8'hA2);
        drive(1'b0, 8'hA3, 1'b1, 6'h21, 1'b1);
        chk_rdy("ho2", 1'b0, 1'b1);
        edge_wait();
        chk_out("ho2", 1'b1, 1'b1, 8'h21);
        // Fresh tenure: three more in2 grants, then in1 gets its turn.
        for (int i = 0; i < 4; i++) begin
            exp_src = (i < 3);
            drive(1'b1, 8'hB0 + 8'(i), 1'b1, 6'h30 + 6'(i), 1'b1);
            chk_rdy($sformatf("ho_cnt%0d", i), !exp_src, exp_src);
            exp_d = exp_src ? {2'b00, 6'h30 + 6'(i)} : 8'hB0 + 8'(i);
            edge_wait();
            chk_out($sformatf("ho_cnt%0d", i), 1'b1, exp_src, exp_d);
        end

        // SIZE = 12 instance: in2 payload zero-extended to 12 bits.
        chk("w12.out_data",  32'(w12_out_data),  32'h02A);
        chk("w12.out_src",   32'(w12_out_src),   32'd1);
        chk("w12.out_valid", 32'(w12_out_valid), 32'd1);
        chk("w12.in1_ready", 32'(w12_in1_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
